// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the cop0 external-interrupt input: synchronises
// request lines, latches edge/level requests, masks, prioritises and claims one source.
module irq_ctrl #(
  parameter int         N_IRQ        = 8,
  parameter logic [1:0] ADDR_PENDING = 2'd0,
  parameter logic [1:0] ADDR_MASK    = 2'd1,
  parameter logic [1:0] ADDR_MODE    = 2'd2,
  parameter logic [1:0] ADDR_ID      = 2'd3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic             i_irq_ack,
  input  logic             i_eret,
  output logic             o_external_interrupt,
  output logic [4:0]       o_irq_id
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t           state_reg, state_next;
  logic [N_IRQ-1:0] s1_reg, s2_reg, s3_reg;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] mask_reg, mode_reg;
  logic [4:0]       id_reg;
  logic [N_IRQ-1:0] act, clr, rise;
  logic [4:0]       win;
  logic             req, claim;
  logic             wr_pending, wr_mask, wr_mode;
  logic             unused_wdata;

  assign wr_pending = i_we && (i_addr == ADDR_PENDING);
  assign wr_mask    = i_we && (i_addr == ADDR_MASK);
  assign wr_mode    = i_we && (i_addr == ADDR_MODE);
  assign unused_wdata = ^i_wdata[31:N_IRQ];

  assign clr  = wr_pending ? i_wdata[N_IRQ-1:0] : '0;
  assign rise = s2_reg & ~s3_reg;
  assign act  = pending_reg & mask_reg;

  // Edge lines: a fresh edge beats a same-cycle W1C. Level lines mirror s2.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_pend
      assign pending_next[gi] = mode_reg[gi] ? ((pending_reg[gi] & ~clr[gi]) | rise[gi])
                                             : s2_reg[gi];
    end
  endgenerate

  always_comb begin
    win = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) win = 5'(i);
    end
  end

  assign req = (state_reg == IDLE) && (|act);

  always_comb begin
    state_next = state_reg;
    claim      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_irq_ack && req) begin
          state_next = SERVICE;
          claim      = 1'b1;
        end
      end
      SERVICE: begin
        if (i_eret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      s3_reg      <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
      mode_reg    <= '1;
      id_reg      <= '0;
      state_reg   <= IDLE;
    end else begin
      s1_reg      <= i_irq;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      pending_reg <= pending_next;
      if (wr_mask) mask_reg <= i_wdata[N_IRQ-1:0];
      if (wr_mode) mode_reg <= i_wdata[N_IRQ-1:0];
      if (claim)   id_reg   <= win;
      state_reg   <= state_next;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_addr == ADDR_PENDING)   o_rdata = 32'(pending_reg);
    else if (i_addr == ADDR_MASK) o_rdata = 32'(mask_reg);
    else if (i_addr == ADDR_MODE) o_rdata = 32'(mode_reg);
    else if (i_addr == ADDR_ID)   o_rdata = {state_reg == SERVICE, 26'b0, id_reg};
  end

  assign o_external_interrupt = req;
  assign o_irq_id             = id_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomised and directed bench for irq_ctrl with a cycle-level reference model
// and a queue-based scoreboard checked by an independent monitor.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  irq;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack, eret;
  logic        ext;
  logic [4:0]  id;

  irq_ctrl #(.N_IRQ(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_rdata(rdata), .i_irq_ack(ack), .i_eret(eret),
    .o_external_interrupt(ext), .o_irq_id(id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ext;
    logic [4:0]  id;
    logic [31:0] rdata;
    logic [1:0]  addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: register contents plus the line values seen at the
  // last three clock edges (h0 newest).
  logic [7:0] m_pend, m_mask, m_mode, h0, h1, h2;
  logic       m_svc;
  logic [4:0] m_id;
  logic [7:0] cur_irq = 8'h00;

  function automatic logic [4:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_mask = 8'h00; m_mode = 8'hFF;
    m_svc = 1'b0; m_id = 5'd0;
    h0 = 8'h00; h1 = 8'h00; h2 = 8'h00;
  endtask

  // Apply one cycle of inputs, queue the expected outputs for that cycle,
  // then advance the model across the clock edge.
  task automatic step(input bit r_n, input logic [7:0] irq_v, input bit we_v,
                      input logic [1:0] a, input logic [31:0] wd,
                      input bit ak, input bit er);
    exp_t e;
    logic [7:0] act, clr, rise, lvl;
    rst_n = r_n; irq = irq_v; we = we_v; addr = a; wdata = wd; ack = ak; eret = er;
    e.ext  = !m_svc && ((m_pend & m_mask) != 0);
    e.id   = m_id;
    e.addr = a;
    case (a)
      2'd0:    e.rdata = {24'd0, m_pend};
      2'd1:    e.rdata = {24'd0, m_mask};
      2'd2:    e.rdata = {24'd0, m_mode};
      default: e.rdata = {m_svc, 26'd0, m_id};
    endcase
    exp_q.push_back(e);
    @(posedge clk);
    if (!r_n) begin
      model_reset();
    end else begin
      act = m_pend & m_mask;
      if (m_svc) begin
        if (er) m_svc = 1'b0;
      end else if (ak && act != 0) begin
        m_svc = 1'b1;
        m_id  = lowest(act);
      end
      clr  = (we_v && a == 2'd0) ? wd[7:0] : 8'h00;
      rise = h1 & ~h2;
      lvl  = h1;
      for (int b = 0; b < 8; b++) begin
        if (m_mode[b]) m_pend[b] = rise[b] | (m_pend[b] & ~clr[b]);
        else           m_pend[b] = lvl[b];
      end
      if (we_v && a == 2'd1) m_mask = wd[7:0];
      if (we_v && a == 2'd2) m_mode = wd[7:0];
      h2 = h1; h1 = h0; h0 = irq_v;
    end
    #1;
  endtask

  int rd_ptr = 0;
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, cur_irq, 0, 2'(rd_ptr), 32'd0, 0, 0);
      rd_ptr++;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1, cur_irq, 1, a, d, 0, 0);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ext !== e.ext) begin
        errors++;
        $display("FAIL ext_int t=%0t got %0b expected %0b", $time, ext, e.ext);
      end
      checks++;
      if (id !== e.id) begin
        errors++;
        $display("FAIL irq_id t=%0t got %0d expected %0d", $time, id, e.id);
      end
      checks++;
      if (rdata !== e.rdata) begin
        errors++;
        $display("FAIL rdata[addr=%0d] t=%0t got 0x%08h expected 0x%08h",
                 e.addr, $time, rdata, e.rdata);
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq = 8'h00; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    ack = 1'b0; eret = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    idle(4);

    // Edge request on line 0 held for three cycles
    wr(2'd1, 32'h0000_0001);
    cur_irq = 8'h01; idle(3);
    cur_irq = 8'h00; idle(5);
    step(1, cur_irq, 0, 2'd3, 32'd0, 1, 0);
    idle(2);
    step(1, cur_irq, 0, 2'd3, 32'd0, 0, 1);
    wr(2'd0, 32'hFFFF_FFFF);
    idle(2);

    // Priority between bits 3 and 5, then re-claim after ERET
    wr(2'd1, 32'hFFFF_FFFF);
    cur_irq = 8'h28; idle(1);
    cur_irq = 8'h00; idle(4);
    step(1, cur_irq, 0, 2'd3, 32'd0, 1, 0);
    idle(2);
    wr(2'd0, 32'h0000_0008);
    step(1, cur_irq, 0, 2'd0, 32'd0, 0, 1);
    idle(1);
    step(1, cur_irq, 0, 2'd3, 32'd0, 1, 0);
    idle(2);

    // New edge while in service, released by ERET together with an ack
    cur_irq = 8'h02; idle(1);
    cur_irq = 8'h00; idle(4);
    step(1, cur_irq, 0, 2'd0, 32'd0, 1, 1);
    idle(2);
    wr(2'd0, 32'hFFFF_FFFF);
    idle(2);

    // Level mode on line 2, W1C has no effect
    wr(2'd2, 32'h0000_0000);
    wr(2'd1, 32'h0000_0004);
    cur_irq = 8'h04; idle(4);
    wr(2'd0, 32'h0000_0004);
    idle(2);
    cur_irq = 8'h00; idle(4);
    wr(2'd2, 32'hFFFF_FF00 | 32'h0000_00FF);

    // Same-cycle W1C and fresh edge on line 0
    wr(2'd1, 32'h0000_0001);
    cur_irq = 8'h01; idle(1);
    cur_irq = 8'h00; idle(4);
    cur_irq = 8'h01; idle(1);
    cur_irq = 8'h00; idle(1);
    wr(2'd0, 32'h0000_0001);
    idle(3);

    // Reset while in service with everything pending
    wr(2'd1, 32'h0000_00FF);
    cur_irq = 8'hFF; idle(1);
    cur_irq = 8'h00; idle(4);
    step(1, cur_irq, 0, 2'd0, 32'd0, 1, 0);
    idle(2);
    step(0, cur_irq, 0, 2'd0, 32'd0, 0, 0);
    idle(4);
    step(1, cur_irq, 0, 2'd3, 32'd0, 0, 1);
    idle(4);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cur_irq = cur_irq ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      step(($urandom % 300) != 0, cur_irq, ($urandom % 5) == 0, 2'($urandom),
           $urandom, ($urandom % 4) == 0, ($urandom % 6) == 0);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that sits directly upstream of the coprocessor-0 exception unit and drives its external-interrupt input. It synchronises N asynchronous device request lines, latches edge-type requests into a pending register, applies a software mask, and holds a single level request toward cop0 until cop0 accepts it. It then blocks further requests until the handler returns with ERET. Software programs it through a small register window and reads the claimed source ID in the handler.

## Interface
- N_IRQ, 8, number of request lines (1..31)
- ADDR_PENDING, 0, pending register address
- ADDR_MASK, 1, mask register address
- ADDR_MODE, 2, mode register address (1 = edge, 0 = level)
- ADDR_ID, 3, claimed-ID register address (read-only)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_irq  in  N_IRQ  asynchronous device request lines
- i_we  in  1  register write strobe
- i_addr  in  2  register address
- i_wdata  in  32  write data
- o_rdata  out  32  read data, combinational on i_addr
- i_irq_ack  in  1  exception-taken pulse from cop0 (its o_exeption)
- i_eret  in  1  ERET executed
- o_external_interrupt  out  1  request to cop0
- o_irq_id  out  5  claimed source index

## Operation
- Synchroniser: per line, two flops s1 and s2, plus s3 as the previous value of s2. Reset clears all of them to 0.
- Edge mode (MODE[i]=1):
  - PENDING[i] sets on s2 & ~s3.
  - It clears on a software write to ADDR_PENDING with wdata[i]=1 (write-1-to-clear).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Level mode (MODE[i]=0): PENDING[i] = s2 each cycle. W1C writes have no effect.
- Active vector: act = PENDING & MASK.
- Priority: the lowest index wins. win = index of the least significant set bit of act.
- FSM:
  - IDLE: o_external_interrupt = |act.
    - If i_irq_ack & o_external_interrupt: o_irq_id <= win and go to SERVICE.
    - i_irq_ack while o_external_interrupt=0 is an exception from another cause. Ignore it.
  - SERVICE: o_external_interrupt = 0.
    - On i_eret: go to IDLE.
    - Pending bits keep accumulating.
  - i_eret while in IDLE is ignored.
- Register reads (o_rdata):
  - PENDING, MASK and MODE read zero-extended to 32 bits.
  - ID reads {service_flag in bit 31, 26'b0, o_irq_id}.
- Register writes:
  - MASK and MODE load wdata[N_IRQ-1:0].
  - A write to ADDR_ID is ignored.
  - Writes take effect at the next clock edge.
- Width rule: bits of wdata above N_IRQ-1 are ignored.
- Reset (i_rst_n=0 at a clock edge):
  - PENDING=0, MASK=0, MODE=all ones, state=IDLE, o_irq_id=0.
  - o_external_interrupt therefore reads 0.
  - Reset mid-service returns to IDLE and discards pending requests.

## Timing
- Edge-mode latency: a rising i_irq sampled at edge k gives s1 at k, s2 at k+1 and PENDING set at edge k+2. o_external_interrupt rises combinationally in the cycle after k+2, if masked in and the FSM is in IDLE.
- Level-mode latency: PENDING follows i_irq with a 2-edge lag. Deasserting the line removes the request without software action.
- o_external_interrupt is a level, held until acknowledged. It is not a pulse.
- ACK and request: at the clock edge where i_irq_ack=1 and o_external_interrupt=1:
  - the FSM enters SERVICE and o_irq_id updates;
  - o_external_interrupt drops in the next cycle.
- Mask write: clearing a MASK bit while in IDLE drops o_external_interrupt the cycle after the write edge. Setting MASK on an already-pending bit raises the request the cycle after the write.
- ERET and request: if i_eret=1 and act≠0, the request re-asserts in the cycle after the ERET edge.
- Simultaneous i_irq_ack and i_eret in SERVICE: i_eret wins and the FSM goes to IDLE.

## Test plan
- Reset, MASK=0x01, pulse i_irq[0] high for 3 cycles -> PENDING reads 0x01 at k+2; o_external_interrupt=1 the cycle after; no further change until ack.
- PENDING=0x28 (bits 3, 5), MASK=0xFF, assert i_irq_ack -> o_irq_id=3, ID reads 0x80000003, o_external_interrupt=0; write PENDING=0x08, assert i_eret -> request re-asserts next cycle; ack -> o_irq_id=5.
- In SERVICE, an edge on i_irq[1] -> PENDING bit 1 set, o_external_interrupt stays 0 until i_eret, then 1.
- MODE=0x00, MASK=0x04, i_irq[2] held high -> request; drop i_irq[2] in IDLE -> PENDING=0 two edges later and request=0; W1C write 0x04 while the line is high -> PENDING stays 0x04.
- W1C clear of bit 0 in the same cycle as a new synchronised edge on line 0 -> PENDING bit 0 remains 1.
- Assert i_rst_n=0 for one edge while in SERVICE with PENDING=0xFF -> PENDING=0, MASK=0, MODE=0xFF, o_irq_id=0, o_external_interrupt=0; i_eret afterwards has no effect.
